// File: rtl/idma_ar_write_coupler.sv
// idma_ar_write_coupler: gates AXI AR requests on write-completion credits.
// Ports: AR in (payload/decouple/valid/ready), AR out to AXI (payload/valid/ready),
//        B observe (valid/ready/decouple), credits_o, busy_o, sticky err_o.
module idma_ar_write_coupler #(
    parameter int unsigned NumAxInFlight = 2,
    parameter int unsigned InFifoDepth   = 2,
    parameter type         axi_ar_chan_t = logic,
    localparam int unsigned CW = $clog2(NumAxInFlight + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          testmode_i,
    input  axi_ar_chan_t  ar_req_i,
    input  logic          ar_decouple_i,
    input  logic          ar_valid_i,
    output logic          ar_ready_o,
    output axi_ar_chan_t  ar_req_o,
    output logic          ar_valid_o,
    input  logic          ar_ready_i,
    input  logic          b_valid_i,
    input  logic          b_ready_i,
    input  logic          b_decouple_i,
    output logic [CW-1:0] credits_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int unsigned PW   = (InFifoDepth > 1) ? $clog2(InFifoDepth) : 1;
    localparam int unsigned CntW = $clog2(InFifoDepth + 1);

    localparam logic [PW-1:0]   LastPtr = PW'(InFifoDepth - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(InFifoDepth);
    localparam logic [CW-1:0]   MaxCred = CW'(NumAxInFlight);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e state_q, state_d;

    axi_ar_chan_t ar_mem  [InFifoDepth];
    logic         dec_mem [InFifoDepth];

    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [CW-1:0]   credits_q;
    logic            err_q;
    axi_ar_chan_t    out_q;

    logic         fifo_empty, fifo_full;
    logic         push, wr_en, rd_en;
    logic         head_valid, head_dec, head_eligible;
    axi_ar_chan_t head_ar;
    logic         credit_ret, take, load;

    // Test mode has no effect on this register-based store.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == DepthC);
    assign push       = ar_valid_i & ~fifo_full;

    // Fall-through head: an AR arriving at an empty store is eligible at once.
    assign head_valid = ~fifo_empty | ar_valid_i;
    assign head_ar    = fifo_empty ? ar_req_i      : ar_mem[rd_ptr_q];
    assign head_dec   = fifo_empty ? ar_decouple_i : dec_mem[rd_ptr_q];

    assign credit_ret = b_valid_i & b_ready_i & ~b_decouple_i;

    // A same-cycle return counts before the take, so a zero pool can still pop.
    assign head_eligible = head_valid &
        (head_dec | (credits_q != '0) | credit_ret);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (head_eligible) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (ar_ready_i) begin
                    if (head_eligible) load = 1'b1;
                    else               state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign take  = load & ~head_dec;
    assign wr_en = push & ~(fifo_empty & load);
    assign rd_en = load & ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ar_mem[wr_ptr_q]  <= ar_req_i;
            dec_mem[wr_ptr_q] <= ar_decouple_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
            end
            if (wr_en && !rd_en)      cnt_q <= cnt_q + CntW'(1);
            else if (rd_en && !wr_en) cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) out_q <= head_ar;
        end
    end

    // Returns against a full pool saturate and flag a protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= MaxCred;
            err_q     <= 1'b0;
        end else begin
            if (credit_ret && credits_q == MaxCred) err_q <= 1'b1;
            if (take && !credit_ret) begin
                credits_q <= credits_q - CW'(1);
            end else if (credit_ret && !take && credits_q != MaxCred) begin
                credits_q <= credits_q + CW'(1);
            end
        end
    end

    assign ar_ready_o = ~fifo_full;
    assign ar_req_o   = out_q;
    assign ar_valid_o = (state_q == FULL);
    assign credits_o  = credits_q;
    assign err_o      = err_q;
    assign busy_o     = ~fifo_empty | (state_q == FULL) | (credits_q != MaxCred);

endmodule

// File: tb/tb_idma_ar_write_coupler.sv
// Testbench for idma_ar_write_coupler: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_idma_ar_write_coupler;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int CW = 2;

    typedef logic [15:0] ar_t;
    typedef struct {
        ar_t ar;
        bit  dec;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_i, testmode_i;
    ar_t           ar_req_i, ar_req_o;
    logic          ar_decouple_i, ar_valid_i, ar_ready_o;
    logic          ar_valid_o, ar_ready_i;
    logic          b_valid_i, b_ready_i, b_decouple_i;
    logic [CW-1:0] credits_o;
    logic          busy_o, err_o;

    idma_ar_write_coupler #(
        .NumAxInFlight(N),
        .InFifoDepth  (D),
        .axi_ar_chan_t(ar_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .testmode_i   (testmode_i),
        .ar_req_i     (ar_req_i),
        .ar_decouple_i(ar_decouple_i),
        .ar_valid_i   (ar_valid_i),
        .ar_ready_o   (ar_ready_o),
        .ar_req_o     (ar_req_o),
        .ar_valid_o   (ar_valid_o),
        .ar_ready_i   (ar_ready_i),
        .b_valid_i    (b_valid_i),
        .b_ready_i    (b_ready_i),
        .b_decouple_i (b_decouple_i),
        .credits_o    (credits_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending ARs, one output slot, a credit pool.
    ent_t q[$];
    bit   s_v;
    ar_t  s_ar;
    int   cred;
    bit   err_m;

    task automatic model_reset();
        q.delete();
        s_v   = 0;
        s_ar  = '0;
        cred  = N;
        err_m = 0;
    endtask

    task automatic compare();
        check("ar_valid", ar_valid_o, s_v);
        check("ar_ready", ar_ready_o, q.size() < D);
        check("credits", credits_o, cred);
        check("busy", busy_o, (q.size() > 0) || s_v || (cred != N));
        check("err", err_o, err_m);
        if (s_v) check("ar_req", ar_req_o, s_ar);
    endtask

    task automatic model_step();
        bit   ret, go;
        ent_t e;
        ret = b_valid_i && b_ready_i && !b_decouple_i;
        if (ar_valid_i && q.size() < D) begin
            e.ar  = ar_req_i;
            e.dec = ar_decouple_i;
            q.push_back(e);
        end
        go = (!s_v || ar_ready_i) && q.size() > 0 &&
             (q[0].dec || cred > 0 || ret);
        if (s_v && ar_ready_i) s_v = 0;
        if (ret && cred == N) err_m = 1;
        if (go) begin
            e    = q.pop_front();
            s_v  = 1;
            s_ar = e.ar;
            if (!e.dec) cred = cred - 1;
        end
        if (ret) cred = (cred + 1 > N) ? N : cred + 1;
    endtask

    task automatic step(input bit av, input bit ad, input ar_t a,
                        input bit ari, input bit bv, input bit bd,
                        input bit rst);
        rst_i         = rst;
        ar_valid_i    = av;
        ar_decouple_i = ad;
        ar_req_i      = a;
        ar_ready_i    = ari;
        b_valid_i     = bv;
        b_ready_i     = 1'b1;
        b_decouple_i  = bd;
        @(negedge clk);
        compare();
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ari);
        for (int i = 0; i < n; i++) step(0, 0, '0, ari, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 1);
    endtask

    initial begin
        testmode_i = 1'b0;
        rst_i      = 1'b1;
        ar_valid_i = 0; ar_decouple_i = 0; ar_req_i = '0; ar_ready_i = 0;
        b_valid_i  = 0; b_ready_i = 1; b_decouple_i = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_i = 1'b0;

        // Reset then idle
        idle(2, 1);
        check("rst_valid", ar_valid_o, 0);
        check("rst_cred", credits_o, 2);
        check("rst_busy", busy_o, 0);

        // Three coupled ARs, no B: third is held with an empty pool
        step(1, 0, 16'h0a01, 1, 0, 0, 0);
        check("c2_v1", ar_valid_o, 1);
        check("c2_a1", ar_req_o, 16'h0a01);
        step(1, 0, 16'h0a02, 1, 0, 0, 0);
        check("c2_a2", ar_req_o, 16'h0a02);
        step(1, 0, 16'h0a03, 1, 0, 0, 0);
        idle(2, 1);
        check("c2_held", ar_valid_o, 0);
        check("c2_cred", credits_o, 0);

        // One coupled B releases the held AR; pool stays empty
        step(0, 0, '0, 1, 1, 0, 0);
        check("c3_v", ar_valid_o, 1);
        check("c3_a", ar_req_o, 16'h0a03);
        check("c3_cred", credits_o, 0);
        idle(1, 1);

        // Decoupled AR bypasses an empty pool
        step(1, 1, 16'h0d01, 1, 0, 0, 0);
        check("c4_v", ar_valid_o, 1);
        check("c4_a", ar_req_o, 16'h0d01);
        check("c4_cred", credits_o, 0);
        idle(1, 1);

        // Coupled head pops on a same-cycle return
        step(1, 0, 16'h0c05, 1, 1, 0, 0);
        check("c5_v", ar_valid_o, 1);
        check("c5_a", ar_req_o, 16'h0c05);
        check("c5_cred", credits_o, 0);
        idle(1, 1);

        // Restore pool, then an extra return is an error
        step(0, 0, '0, 1, 1, 0, 0);
        step(0, 0, '0, 1, 1, 0, 0);
        check("c6_full", credits_o, 2);
        step(0, 0, '0, 1, 1, 0, 0);
        check("c6_err", err_o, 1);
        check("c6_cred", credits_o, 2);
        idle(3, 1);
        check("c6_sticky", err_o, 1);
        do_reset();
        check("c6_clr", err_o, 0);

        // Backpressure: output held stable, store fills up
        step(1, 0, 16'h0b00, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, ar_t'(16'h0b00 + i), 0, 0, 0, 0);
            check("c7_hold", ar_req_o, 16'h0b00);
        end
        check("c7_ready", ar_ready_o, 0);
        check("c7_valid", ar_valid_o, 1);
        idle(4, 1);

        // Random traffic with occasional mid-transfer reset
        for (int i = 0; i < 3000; i++) begin
            bit rs, bd, bv;
            rs = ($urandom_range(0, 299) == 0);
            bd = $urandom_range(0, 3) == 0;
            bv = ($urandom_range(0, 2) == 0) && (bd || cred < N);
            step($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 ar_t'($urandom), $urandom_range(0, 3) != 0, bv, bd, rs);
        end
        idle(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
